// File: rtl/hb_wb_master.sv
// Hostbus-to-Wishbone master: one classic Wishbone cycle per hostbus request,
// with a stb-without-ack watchdog so an unmapped address cannot hang the host.
module hb_wb_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hb_req,
  input  logic              hb_write,
  input  logic [ADDR_W-1:0] hb_addr,
  input  logic [DATA_W-1:0] hb_wrData,
  output logic              hb_busy,
  output logic              hb_done,
  output logic              hb_err,
  output logic [DATA_W-1:0] hb_rdData,
  output logic              glob_cycle,
  output logic              glob_strobe,
  output logic              glob_write,
  output logic [ADDR_W-1:0] glob_addr,
  output logic [DATA_W-1:0] glob_wrData,
  input  logic              glob_ack,
  input  logic [DATA_W-1:0] glob_rdData
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, FIN} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cyc_d, busy_d, done_d, err_d, write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;

  // CYC and STB are always asserted and dropped together.
  assign glob_strobe = glob_cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      glob_cycle  <= 1'b0;
      glob_write  <= 1'b0;
      glob_addr   <= '0;
      glob_wrData <= '0;
      hb_busy     <= 1'b0;
      hb_done     <= 1'b0;
      hb_err      <= 1'b0;
      hb_rdData   <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      glob_cycle  <= cyc_d;
      glob_write  <= write_d;
      glob_addr   <= addr_d;
      glob_wrData <= wdata_d;
      hb_busy     <= busy_d;
      hb_done     <= done_d;
      hb_err      <= err_d;
      hb_rdData   <= rdata_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cyc_d   = glob_cycle;
    write_d = glob_write;
    addr_d  = glob_addr;
    wdata_d = glob_wrData;
    busy_d  = hb_busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = hb_rdData;
    unique case (state)
      IDLE: begin
        if (hb_req) begin
          write_d = hb_write;
          addr_d  = hb_addr;
          wdata_d = hb_wrData;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is tested first so an ack on the timeout edge still completes.
        if (glob_ack) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
          if (!glob_write) rdata_d = glob_rdData;
        end else if (cnt == CNT_LAST) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hb_wb_master.sv
// Scoreboard bench for hb_wb_master (TIMEOUT=8): expected hostbus responses and
// bus cycles are queued by the stimulus and checked by independent monitors.
module tb_hb_wb_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hb_req = 1'b0, hb_write = 1'b0;
  logic [15:0] hb_addr = '0, hb_wrData = '0;
  logic        hb_busy, hb_done, hb_err;
  logic [15:0] hb_rdData;
  logic        glob_cycle, glob_strobe, glob_write;
  logic [15:0] glob_addr, glob_wrData;
  logic        glob_ack = 1'b0;
  logic [15:0] glob_rdData = 16'hDEAD;

  hb_wb_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .hb_req(hb_req), .hb_write(hb_write), .hb_addr(hb_addr), .hb_wrData(hb_wrData),
    .hb_busy(hb_busy), .hb_done(hb_done), .hb_err(hb_err), .hb_rdData(hb_rdData),
    .glob_cycle(glob_cycle), .glob_strobe(glob_strobe), .glob_write(glob_write),
    .glob_addr(glob_addr), .glob_wrData(glob_wrData),
    .glob_ack(glob_ack), .glob_rdData(glob_rdData)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [15:0] rdata; int lat; int t0; } resp_t;
  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; int len; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int ack_at = 0;
  logic [15:0] ack_data = '0;
  logic [15:0] last_rd = '0;
  logic seen_0010 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Slave model: acks on the ack_at-th clock of stb (0 = never).
  int scnt = 0;
  always @(posedge clk) begin
    #1;
    if (glob_strobe) begin
      scnt++;
      glob_ack    = (ack_at != 0 && scnt == ack_at);
      glob_rdData = glob_ack ? ack_data : 16'hDEAD;
    end else begin
      scnt        = 0;
      glob_ack    = 1'b0;
      glob_rdData = 16'hDEAD;
    end
  end

  // Response monitor.
  logic busy_next = 1'b0;
  always @(negedge clk) begin
    if (busy_next) begin
      chk("busy_clear_after_resp", {31'd0, hb_busy}, 32'd0);
      busy_next = 1'b0;
    end
    if (hb_done || hb_err) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, hb_done, hb_err}, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_done", {31'd0, hb_done}, {31'd0, ~r.err});
        chk("resp_err", {31'd0, hb_err}, {31'd0, r.err});
        chk("resp_rdData", {16'd0, hb_rdData}, {16'd0, r.rdata});
        chk("resp_latency", cyc_n - r.t0, r.lat);
        chk("busy_at_resp", {31'd0, hb_busy}, 32'd1);
        busy_next = 1'b1;
      end
    end
  end

  // Bus monitor.
  logic in_cyc = 1'b0;
  int blen = 0;
  logic bwe;
  logic [15:0] baddr, bwdata;
  always @(negedge clk) begin
    if (glob_addr == 16'h0010) seen_0010 = 1'b1;
    if (rst) begin
      in_cyc = 1'b0;
    end else if (glob_strobe) begin
      if (!in_cyc) begin
        in_cyc = 1'b1; blen = 0;
        bwe = glob_write; baddr = glob_addr; bwdata = glob_wrData;
      end
      blen++;
      if (glob_cycle !== 1'b1) chk("cyc_eq_stb", {31'd0, glob_cycle}, 32'd1);
    end else if (in_cyc) begin
      in_cyc = 1'b0;
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_cycle", {16'd0, baddr}, 32'hFFFF_FFFF);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("bus_len", blen, b.len);
        chk("bus_addr", {16'd0, baddr}, {16'd0, b.addr});
        chk("bus_we", {31'd0, bwe}, {31'd0, b.we});
        if (b.we) chk("bus_wdata", {16'd0, bwdata}, {16'd0, b.wdata});
      end
    end
  end

  task automatic wait_resp();
    int n = 0;
    @(negedge clk);
    while (!(hb_done || hb_err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("resp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     input int ack, input logic [15:0] ad, input logic poke);
    resp_t r;
    bus_t b;
    @(posedge clk); #1;
    ack_at = ack; ack_data = ad;
    hb_req = 1'b1; hb_write = we; hb_addr = addr; hb_wrData = wd;
    r.err = (ack == 0);
    if (!we && ack != 0) last_rd = ad;
    r.rdata = last_rd;
    r.lat = (ack == 0) ? TMO + 1 : ack + 1;
    r.t0 = cyc_n;
    resp_q.push_back(r);
    b.we = we; b.addr = addr; b.wdata = wd; b.len = (ack == 0) ? TMO : ack;
    bus_q.push_back(b);
    @(posedge clk); #1;
    if (poke) begin
      hb_write = 1'b1; hb_addr = 16'h0010; hb_wrData = 16'h1111;
      @(posedge clk); #1;
    end
    hb_req = 1'b0;
    wait_resp();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, hb_busy}, 32'd0);
    chk("rst_done_err", {30'd0, hb_done, hb_err}, 32'd0);
    chk("rst_cyc_stb", {30'd0, glob_cycle, glob_strobe}, 32'd0);
    chk("rst_rdData", {16'd0, hb_rdData}, 32'd0);
    chk("rst_addr", {16'd0, glob_addr}, 32'd0);

    txn(1'b1, 16'h0003, 16'hA5A5, 1, 16'hBEEF, 1'b0);  // write, immediate ack
    txn(1'b0, 16'h0105, 16'h0000, 4, 16'h55AA, 1'b1);  // read, 3 waits, poke while busy
    txn(1'b1, 16'h0044, 16'h1357, 2, 16'hBEEF, 1'b0);  // write: rdData must hold
    txn(1'b0, 16'h7F00, 16'h0000, 0, 16'h0000, 1'b0);  // timeout
    txn(1'b0, 16'h0020, 16'h0000, TMO, 16'h1234, 1'b0); // ack on timeout edge
    txn(1'b0, 16'h0007, 16'h0000, 1, 16'h0F0F, 1'b0);  // read, immediate ack

    // Reset in the middle of a never-acked cycle.
    @(posedge clk); #1;
    ack_at = 0;
    hb_req = 1'b1; hb_write = 1'b0; hb_addr = 16'h0200;
    @(posedge clk); #1 hb_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", {30'd0, glob_cycle, glob_strobe}, 32'd0);
    chk("midrst_busy", {31'd0, hb_busy}, 32'd0);
    chk("midrst_done_err", {30'd0, hb_done, hb_err}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    last_rd = '0;
    txn(1'b0, 16'h0300, 16'h0000, 2, 16'hC0DE, 1'b0);

    repeat (4) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("addr_0010_never_seen", {31'd0, seen_0010}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hb_wb_master.md
Name: hb_wb_master

Overview:
- Hostbus-side front end of the gateway.
- Accepts single read/write requests from the hostbus port and runs one classic Wishbone cycle per request on the global bus that feeds wb_intercon (glob_* side).
- Returns read data and completion/error status to the hostbus.
- Includes a bus-timeout watchdog so an unmapped address cannot hang the host.

Parameters:
- ADDR_W, 16, width of hostbus and Wishbone address
- DATA_W, 16, width of read/write data
- TIMEOUT, 64, cycles with stb high and no ack before the cycle is aborted (range 2..1023)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- hb_req  in  1  request strobe; sampled only while hb_busy=0
- hb_write  in  1  1=write, 0=read; sampled with hb_req
- hb_addr  in  ADDR_W  request address; sampled with hb_req
- hb_wrData  in  DATA_W  write data; sampled with hb_req
- hb_busy  out  1  high from the cycle after acceptance until done/err pulse
- hb_done  out  1  one-cycle pulse: transaction completed with ack
- hb_err  out  1  one-cycle pulse: transaction aborted by timeout
- hb_rdData  out  DATA_W  read data; valid from the hb_done pulse, held until the next read completes
- glob_cycle  out  1  Wishbone CYC
- glob_strobe  out  1  Wishbone STB
- glob_write  out  1  Wishbone WE
- glob_addr  out  ADDR_W  Wishbone ADR
- glob_wrData  out  DATA_W  Wishbone DAT master-to-slave
- glob_ack  in  1  Wishbone ACK from interconnect
- glob_rdData  in  DATA_W  Wishbone DAT slave-to-master

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, timeout counter 0, hb_rdData 0.
- State machine: IDLE, BUS, FIN.
- IDLE:
  - hb_req=1 registers hb_write, hb_addr, hb_wrData onto glob_write, glob_addr, glob_wrData.
  - Same edge sets glob_cycle=glob_strobe=1 and hb_busy=1, then goes to BUS.
  - Wishbone cycle starts one clock after hb_req.
- BUS:
  - glob_cycle, glob_strobe, glob_addr, glob_write and glob_wrData are held stable.
  - Counter increments each cycle that glob_ack=0.
  - glob_ack=1 on a clock edge:
    - drop glob_cycle and glob_strobe on that edge;
    - if read, capture glob_rdData into hb_rdData on that edge;
    - pulse hb_done=1 for exactly one cycle;
    - go to FIN.
  - Counter reaching TIMEOUT-1 with ack still 0:
    - drop cyc/stb;
    - pulse hb_err=1 for one cycle;
    - leave hb_rdData unchanged;
    - go to FIN.
  - If ack arrives on the same edge the counter hits TIMEOUT-1, ack wins: hb_done, not hb_err.
- FIN:
  - One idle cycle; hb_busy deasserts on the edge leaving FIN.
  - Counter is cleared and the state returns to IDLE.
  - Guarantees at least one clock with cyc=0 between bus cycles.
- Minimum transaction length: hb_req to hb_done is 2 clocks when the slave acks in the first stb cycle; back-to-back requests every 3 clocks.
- hb_req while hb_busy=1: ignored, no queuing, no side effects.
- glob_ack while in IDLE or FIN (spurious): ignored.
- glob_addr, glob_write, glob_wrData hold their last values after the cycle ends; slaves must qualify with glob_strobe.
- Async reset mid-cycle drops cyc/stb immediately with no done/err pulse; the host must reissue.
- No pipelining, no burst, no retry/err input from slaves; byte selects are not supported (full-word only).

Test Plan:
- Write, immediate ack: hb_req with write=1, addr=0x0003, wrData=0xA5A5; slave acks on first stb clock. Required: glob_addr=0x0003, glob_wrData=0xA5A5, glob_write=1 for 1 clock; hb_done pulses 2 clocks after hb_req; hb_busy clears 1 clock later.
- Read with 3 wait states: hb_req read, addr=0x0105; slave returns 0x55AA with ack on the 4th stb clock. Required: cyc/stb high exactly 4 clocks; hb_rdData=0x55AA with the hb_done pulse; hb_rdData holds after an intervening write.
- Timeout: TIMEOUT=8, read from unmapped addr=0x7F00, ack never asserted. Required: stb high exactly 8 clocks; hb_err single pulse; hb_done never asserted; hb_rdData unchanged from the previous read.
- Ack on the timeout edge: ack asserted in the 8th stb clock with TIMEOUT=8. Required: hb_done pulses and hb_err stays 0.
- Request while busy: second hb_req with addr=0x0010 during a wait-stated read. Required: ignored; only one cycle appears on the bus; glob_addr never shows 0x0010.
- Reset mid-cycle: assert rst asynchronously (between clock edges) while stb=1. Required: cyc/stb/busy go to 0 immediately, no done/err pulse; after reset release a new request completes normally.
